bp_cce_msg_mode_arbiter: RTL

Shares the CCE's external LCE and memory message ports between the cached (coherent) message unit and the uncached message unit, and sequences safe switching between them when the configured CCE mode changes. Sits between the buffered CCE port FIFOs and the two message units. Tracks outstanding memory commands, drains them on a mode change, and only then hands the ports to the other unit, so no memory response is delivered to the wrong unit.

---
 rtl/bp_cce_msg_mode_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/bp_cce_msg_mode_arbiter.sv
// bp_cce_msg_mode_arbiter
// Shares the CCE's external LCE and memory message ports between the cached
// (coherent) unit "c" and the uncached unit "u". When the configured mode
// changes, in-flight memory commands are drained before the ports are handed
// over, so that no memory response reaches the wrong unit.
//
// Ports:
//   clk_i, reset_i                         clock, synchronous active-high reset
//   mode_i                                 requested mode (0 cached, 1 uncached)
//   lce_req_*, lce_resp_*, mem_resp_*      inbound channels from port FIFOs (valid->yumi)
//   lce_cmd_*, mem_cmd_*                   outbound channels to ports (ready&valid)
//   {c,u}_lce_req_*, c_lce_resp_*,
//   {c,u}_mem_resp_*                       unit-side copies of inbound channels
//   {c,u}_lce_cmd_*, {c,u}_mem_cmd_*       unit-side outbound channels
//   owner_o                                unit currently owning the ports
//   outstanding_o                          in-flight memory command count
//   switch_busy_o                          high while draining for a mode switch
module bp_cce_msg_mode_arbiter #(
  parameter int mem_msg_width_p   = 0,
  parameter int lce_req_width_p   = 0,
  parameter int lce_resp_width_p  = 0,
  parameter int lce_cmd_width_p   = 0,
  parameter int max_outstanding_p = 4,
  localparam int cnt_w = $clog2(max_outstanding_p + 1)
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        mode_i,

  input  logic [lce_req_width_p-1:0]  lce_req_i,
  input  logic                        lce_req_v_i,
  output logic                        lce_req_yumi_o,
  input  logic [lce_resp_width_p-1:0] lce_resp_i,
  input  logic                        lce_resp_v_i,
  output logic                        lce_resp_yumi_o,
  input  logic [mem_msg_width_p-1:0]  mem_resp_i,
  input  logic                        mem_resp_v_i,
  output logic                        mem_resp_yumi_o,
  output logic [lce_cmd_width_p-1:0]  lce_cmd_o,
  output logic                        lce_cmd_v_o,
  input  logic                        lce_cmd_ready_i,
  output logic [mem_msg_width_p-1:0]  mem_cmd_o,
  output logic                        mem_cmd_v_o,
  input  logic                        mem_cmd_ready_i,

  output logic [lce_req_width_p-1:0]  c_lce_req_o,
  output logic                        c_lce_req_v_o,
  input  logic                        c_lce_req_yumi_i,
  output logic [lce_req_width_p-1:0]  u_lce_req_o,
  output logic                        u_lce_req_v_o,
  input  logic                        u_lce_req_yumi_i,
  output logic [lce_resp_width_p-1:0] c_lce_resp_o,
  output logic                        c_lce_resp_v_o,
  input  logic                        c_lce_resp_yumi_i,
  output logic [mem_msg_width_p-1:0]  c_mem_resp_o,
  output logic                        c_mem_resp_v_o,
  input  logic                        c_mem_resp_yumi_i,
  output logic [mem_msg_width_p-1:0]  u_mem_resp_o,
  output logic                        u_mem_resp_v_o,
  input  logic                        u_mem_resp_yumi_i,

  input  logic [lce_cmd_width_p-1:0]  c_lce_cmd_i,
  input  logic                        c_lce_cmd_v_i,
  output logic                        c_lce_cmd_ready_o,
  input  logic [lce_cmd_width_p-1:0]  u_lce_cmd_i,
  input  logic                        u_lce_cmd_v_i,
  output logic                        u_lce_cmd_ready_o,
  input  logic [mem_msg_width_p-1:0]  c_mem_cmd_i,
  input  logic                        c_mem_cmd_v_i,
  output logic                        c_mem_cmd_ready_o,
  input  logic [mem_msg_width_p-1:0]  u_mem_cmd_i,
  input  logic                        u_mem_cmd_v_i,
  output logic                        u_mem_cmd_ready_o,

  output logic                        owner_o,
  output logic [cnt_w-1:0]            outstanding_o,
  output logic                        switch_busy_o
);

  typedef enum logic {ACTIVE = 1'b0, DRAIN = 1'b1} state_e;

  localparam logic [cnt_w-1:0] max_cnt = cnt_w'(max_outstanding_p);

  state_e            state, state_n;
  logic              owner, owner_n;
  logic [cnt_w-1:0]  cnt;
  logic              live, admit, cmd_hs, resp_hs;

  // state register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= ACTIVE;
      owner <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      if (cmd_hs && !resp_hs)
        cnt <= cnt + 1'b1;
      else if (resp_hs && !cmd_hs && cnt != '0)
        cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i)
      assert (!(resp_hs && cnt == '0))
        else $error("memory response accepted with no command outstanding");
  end

  // next-state logic
  always_comb begin
    state_n = state;
    owner_n = owner;
    unique case (state)
      ACTIVE: if (mode_i != owner) state_n = DRAIN;
      DRAIN: begin
        // Hand over only once nothing for the current owner can still arrive
        // or be in progress on the shared ports.
        if (cnt == '0 && !(owner ? u_lce_cmd_v_i : c_lce_cmd_v_i) && !mem_resp_v_i) begin
          state_n = ACTIVE;
          owner_n = mode_i;
        end
      end
      default: state_n = ACTIVE;
    endcase
  end

  // output / routing logic
  always_comb begin
    live  = !reset_i;
    admit = live && (state == ACTIVE) && (cnt < max_cnt);

    c_lce_req_o  = lce_req_i;
    u_lce_req_o  = lce_req_i;
    c_lce_resp_o = lce_resp_i;
    c_mem_resp_o = mem_resp_i;
    u_mem_resp_o = mem_resp_i;
    lce_cmd_o    = owner ? u_lce_cmd_i : c_lce_cmd_i;
    mem_cmd_o    = owner ? u_mem_cmd_i : c_mem_cmd_i;

    c_lce_req_v_o  = live && (state == ACTIVE) && !owner && lce_req_v_i;
    u_lce_req_v_o  = live && (state == ACTIVE) &&  owner && lce_req_v_i;
    lce_req_yumi_o = live && (state == ACTIVE) && (owner ? u_lce_req_yumi_i : c_lce_req_yumi_i);

    c_lce_resp_v_o  = live && !owner && lce_resp_v_i;
    lce_resp_yumi_o = live && !owner && c_lce_resp_yumi_i;

    c_mem_resp_v_o  = live && !owner && mem_resp_v_i;
    u_mem_resp_v_o  = live &&  owner && mem_resp_v_i;
    mem_resp_yumi_o = live && (owner ? u_mem_resp_yumi_i : c_mem_resp_yumi_i);

    lce_cmd_v_o       = live && (owner ? u_lce_cmd_v_i : c_lce_cmd_v_i);
    c_lce_cmd_ready_o = live && !owner && lce_cmd_ready_i;
    u_lce_cmd_ready_o = live &&  owner && lce_cmd_ready_i;

    mem_cmd_v_o       = admit && (owner ? u_mem_cmd_v_i : c_mem_cmd_v_i);
    c_mem_cmd_ready_o = admit && !owner && mem_cmd_ready_i;
    u_mem_cmd_ready_o = admit &&  owner && mem_cmd_ready_i;

    cmd_hs  = mem_cmd_v_o && mem_cmd_ready_i;
    resp_hs = mem_resp_yumi_o;

    owner_o       = owner;
    outstanding_o = cnt;
    switch_busy_o = (state == DRAIN);
  end

endmodule
